// File: rtl/count_mon_pkg.sv
// Shared types and helpers for the count wrap monitor.
// The optional build macro RESTART_CLR_EN lives in count_wrap_monitor.sv.
package count_mon_pkg;

  localparam int CNT_W_DEF  = 4;
  localparam int WRAP_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    CLS_STALL   = 3'd0,
    CLS_STEP    = 3'd1,
    CLS_WRAP    = 3'd2,
    CLS_RESTART = 3'd3,
    CLS_FAULT   = 3'd4
  } trans_class_t;

  // Largest value representable on a w-bit count bus.
  function automatic int unsigned max_of(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/count_step_classifier.sv
// Combinational classifier of one count transition (prev -> curr).
module count_step_classifier
  import count_mon_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic [CNT_W-1:0] prev,
  input  logic [CNT_W-1:0] curr,
  output trans_class_t     cls
);

  localparam logic [CNT_W-1:0] MAX  = CNT_W'(max_of(CNT_W));
  localparam logic [CNT_W-1:0] ZERO = '0;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  // Priority order matters: an upstream held in reset (0 -> 0) is a stall,
  // and MAX -> 0 is a wrap before it could be mistaken for a restart.
  always_comb begin
    cls = CLS_FAULT;
    if (curr == prev)
      cls = CLS_STALL;
    else if (prev == MAX && curr == ZERO)
      cls = CLS_WRAP;
    else if (prev != MAX && curr == prev + ONE)
      cls = CLS_STEP;
    else if (curr == ZERO && prev != ZERO && prev != MAX)
      cls = CLS_RESTART;
  end

endmodule

// File: rtl/count_wrap_monitor.sv
// Monitor for an upstream counter: counts wraps, flags restarts and
// latches the first illegal transition. All outputs are registered.
// Build option: RESTART_CLR_EN -- a restart also clears wraps and wraps_ovf.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | first cycle after reset, capture count as reference only
// ST_TRACK | classify every transition against the previous sample
// ST_FAULT | illegal jump seen, everything frozen until rst
module count_wrap_monitor
  import count_mon_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int WRAP_W = WRAP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  count,
  output logic [WRAP_W-1:0] wraps,
  output logic              wraps_ovf,
  output logic              wrap_pulse,
  output logic              restart_pulse,
  output logic              fault,
  output logic [CNT_W-1:0]  fault_prev,
  output logic [CNT_W-1:0]  fault_curr
);

  localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);

  state_t           state;
  logic [CNT_W-1:0] prev;
  trans_class_t     cls;

  count_step_classifier #(.CNT_W(CNT_W)) u_classifier (
    .prev (prev),
    .curr (count),
    .cls  (cls)
  );

  // FSM, reference sample, wrap accumulator and all output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      prev          <= '0;
      wraps         <= '0;
      wraps_ovf     <= 1'b0;
      wrap_pulse    <= 1'b0;
      restart_pulse <= 1'b0;
      fault         <= 1'b0;
      fault_prev    <= '0;
      fault_curr    <= '0;
    end else begin
      wrap_pulse    <= 1'b0;
      restart_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          prev  <= count;
          state <= ST_TRACK;
        end
        ST_TRACK: begin
          prev <= count;
          case (cls)
            CLS_WRAP: begin
              wraps      <= wraps + WRAP_ONE;
              wrap_pulse <= 1'b1;
              if (&wraps)
                wraps_ovf <= 1'b1;
            end
            CLS_RESTART: begin
              restart_pulse <= 1'b1;
`ifdef RESTART_CLR_EN
              wraps         <= '0;
              wraps_ovf     <= 1'b0;
`endif
            end
            CLS_FAULT: begin
              fault      <= 1'b1;
              fault_prev <= prev;
              fault_curr <= count;
              state      <= ST_FAULT;
            end
            default: ;
          endcase
        end
        ST_FAULT: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_count_wrap_monitor.sv
// Directed bench for count_wrap_monitor: one 8-bit-accumulator instance and
// one 2-bit-accumulator instance share clock, reset and count stimulus.
module tb_count_wrap_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] count;

  logic [7:0] wraps;
  logic       wraps_ovf, wrap_pulse, restart_pulse, fault;
  logic [3:0] fault_prev, fault_curr;

  logic [1:0] wraps2;
  logic       wraps_ovf2, wrap_pulse2, restart_pulse2, fault2;
  logic [3:0] fault_prev2, fault_curr2;

  int n_checks = 0;
  int n_errors = 0;
  int n_wp = 0;
  int n_rp = 0;
  int n_ft = 0;
  int base_wp, base_rp, base_ft;
  logic [7:0] exp_wraps;

  always #5 clk = ~clk;

  count_wrap_monitor #(.CNT_W(4), .WRAP_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .count         (count),
    .wraps         (wraps),
    .wraps_ovf     (wraps_ovf),
    .wrap_pulse    (wrap_pulse),
    .restart_pulse (restart_pulse),
    .fault         (fault),
    .fault_prev    (fault_prev),
    .fault_curr    (fault_curr)
  );

  count_wrap_monitor #(.CNT_W(4), .WRAP_W(2)) dut2 (
    .clk           (clk),
    .rst           (rst),
    .count         (count),
    .wraps         (wraps2),
    .wraps_ovf     (wraps_ovf2),
    .wrap_pulse    (wrap_pulse2),
    .restart_pulse (restart_pulse2),
    .fault         (fault2),
    .fault_prev    (fault_prev2),
    .fault_curr    (fault_curr2)
  );

  // Drive count on the falling edge, then observe just after the rising edge.
  task automatic tick(input logic [3:0] c);
    @(negedge clk);
    count = c;
    @(posedge clk);
    #1;
    if (wrap_pulse)    n_wp++;
    if (restart_pulse) n_rp++;
    if (wrap_pulse && restart_pulse) n_ft++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst   = 1'b1;
    count = 4'd0;
    tick(4'd0);
    tick(4'd0);
    chk("rst_wraps", 32'(wraps), 32'd0);
    chk("rst_ovf", 32'(wraps_ovf), 32'd0);
    chk("rst_pulses", {30'd0, wrap_pulse, restart_pulse}, 32'd0);
    chk("rst_fault", {23'd0, fault, fault_prev, fault_curr}, 32'd0);

    // Free run 0..15, 0..15, 0..3
    rst = 1'b0;
    base_wp = n_wp;
    base_rp = n_rp;
    for (int i = 0; i < 36; i++) begin
      tick(4'(i % 16));
      if (i == 16) begin
        chk("first_wrap_pulse", 32'(wrap_pulse), 32'd1);
        chk("first_wrap_count", 32'(wraps), 32'd1);
      end
      if (i == 17)
        chk("wrap_pulse_one_cycle", 32'(wrap_pulse), 32'd0);
    end
    chk("run_wrap_pulses", 32'(n_wp - base_wp), 32'd2);
    chk("run_restart_pulses", 32'(n_rp - base_rp), 32'd0);
    chk("run_wraps", 32'(wraps), 32'd2);
    chk("run_fault", 32'(fault), 32'd0);

    // Upstream restart at 9: 9 -> 0, hold 0, then 1
    for (int v = 4; v <= 9; v++) tick(4'(v));
`ifdef RESTART_CLR_EN
    exp_wraps = 8'd0;
`else
    exp_wraps = 8'd2;
`endif
    tick(4'd0);
    chk("restart_pulse", 32'(restart_pulse), 32'd1);
    chk("restart_no_wrap_pulse", 32'(wrap_pulse), 32'd0);
    chk("restart_wraps", 32'(wraps), 32'(exp_wraps));
    tick(4'd0);
    chk("restart_pulse_one_cycle", 32'(restart_pulse), 32'd0);
    tick(4'd1);
    chk("restart_no_fault", 32'(fault), 32'd0);

    // Illegal jump 5 -> 7
    for (int v = 2; v <= 5; v++) tick(4'(v));
    chk("pre_fault", 32'(fault), 32'd0);
    tick(4'd7);
    chk("fault_set", 32'(fault), 32'd1);
    chk("fault_prev", 32'(fault_prev), 32'd5);
    chk("fault_curr", 32'(fault_curr), 32'd7);
    base_wp = n_wp;
    base_rp = n_rp;
    for (int v = 8; v <= 15; v++) tick(4'(v));
    tick(4'd0);
    tick(4'd3);
    chk("frozen_wrap_pulses", 32'(n_wp - base_wp), 32'd0);
    chk("frozen_restart_pulses", 32'(n_rp - base_rp), 32'd0);
    chk("frozen_wraps", 32'(wraps), 32'(exp_wraps));
    chk("frozen_fault_fields", {23'd0, fault, fault_prev, fault_curr}, {23'd0, 1'b1, 4'd5, 4'd7});

    // Reset from FAULT
    rst = 1'b1;
    tick(4'd0);
    chk("fault_rst_fault", 32'(fault), 32'd0);
    chk("fault_rst_wraps", 32'(wraps), 32'd0);
    chk("fault_rst_fields", {24'd0, fault_prev, fault_curr}, 32'd0);
    chk("fault_rst_wraps2", {29'd0, wraps_ovf2, wraps2}, 32'd0);

    // Resume: IDLE captures 15, then four full wraps
    rst = 1'b0;
    tick(4'd15);
    chk("idle_no_event", {30'd0, wrap_pulse, restart_pulse}, 32'd0);
    for (int w = 1; w <= 4; w++) begin
      tick(4'd0);
      chk("resume_wrap_pulse", 32'(wrap_pulse), 32'd1);
      chk("w2_wraps", 32'(wraps2), 32'(w % 4));
      chk("w2_ovf", 32'(wraps_ovf2), (w == 4) ? 32'd1 : 32'd0);
      if (w < 4)
        for (int v = 1; v <= 15; v++) tick(4'(v));
    end
    chk("w8_wraps", 32'(wraps), 32'd4);
    chk("w8_ovf", 32'(wraps_ovf), 32'd0);

    // Hold at 6 for five cycles, then step to 7
    base_wp = n_wp;
    base_rp = n_rp;
    for (int v = 1; v <= 6; v++) tick(4'(v));
    for (int k = 0; k < 4; k++) tick(4'd6);
    tick(4'd7);
    chk("hold_pulses", 32'((n_wp - base_wp) + (n_rp - base_rp)), 32'd0);
    chk("hold_fault", 32'(fault), 32'd0);
    chk("hold_wraps", 32'(wraps), 32'd4);
    chk("w2_ovf_sticky", 32'(wraps_ovf2), 32'd1);
    chk("pulses_exclusive", 32'(n_ft), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/count_wrap_monitor.md
Name: count_wrap_monitor

Overview:
- Sits directly downstream of the 4-bit synchronous-reset counter and samples its `count` bus every clock.
- Classifies each count transition as step, stall, wrap, restart or fault.
- Accumulates wraps in a wider upper-digit register, giving an effective cascaded count.
- Flags illegal jumps as a sticky fault for bring-up and verification.
- All outputs are registered.

Parameters:
- CNT_W, 4, width of the upstream count bus; max value is 2^CNT_W-1.
- WRAP_W, 8, width of the wrap accumulator.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- count  input  CNT_W  upstream counter value, sampled every clk
- wraps  output  WRAP_W  number of MAX->0 wraps seen since reset
- wraps_ovf  output  1  sticky; set when wraps rolls from all-ones to 0
- wrap_pulse  output  1  one-cycle pulse per detected wrap
- restart_pulse  output  1  one-cycle pulse when upstream restarts (reset seen)
- fault  output  1  sticky illegal-transition flag
- fault_prev  output  CNT_W  previous sample at the moment of fault
- fault_curr  output  CNT_W  offending sample at the moment of fault

Behaviour:
- Reset (synchronous, active-high, dominates all other events): state=IDLE, prev=0, all outputs 0.
- IDLE: the first cycle after rst deasserts captures count into prev and moves to TRACK. No events are issued in IDLE.
- TRACK: each cycle compares count (C) against prev (P), with MAX=2^CNT_W-1. Classification has this priority:
  - C==P: stall. No event. This also covers upstream held in reset (P==0, C==0).
  - P==MAX and C==0: wrap. wraps<=wraps+1 (mod 2^WRAP_W); wrap_pulse=1 next cycle.
  - P!=MAX and C==P+1: step. No event.
  - C==0, P not in {0, MAX}: restart. restart_pulse=1 next cycle; wraps unchanged (see optional feature).
  - Otherwise: fault. fault<=1, fault_prev<=P, fault_curr<=C; state<=FAULT.
  - prev<=C every TRACK cycle.
- FAULT: terminal until rst.
  - wraps, wraps_ovf and fault_* are frozen.
  - wrap_pulse and restart_pulse are held at 0.
- Latency: an event is visible on outputs 1 cycle after the clk edge that sampled the triggering count.
- wraps_ovf: set in the same cycle that wraps goes from all-ones to 0; cleared only by rst.
- Pulses never assert together. wrap and restart are mutually exclusive by classification.
- rst mid-operation, including in FAULT: returns to IDLE next edge; all state is cleared.
- No combinational path from count to any output.

Optional Feature:
- Macro RESTART_CLR_EN.
- Defined: a restart classification also clears wraps to 0 and clears wraps_ovf in the same update.
- Undefined: restart only pulses restart_pulse; wraps and wraps_ovf are preserved.

Decomposition:
- Shared package count_mon_pkg holds:
  - state enum: IDLE, TRACK, FAULT (2-bit encoding).
  - transition-class enum: STALL, STEP, WRAP, RESTART, FAULT.
  - localparam helpers for MAX.
- One sub-module, count_step_classifier: purely combinational (P, C) -> class, parameterised on CNT_W, reused by the bench's scoreboard.
- Top holds the FSM, prev register, accumulator and output registers.

Test Plan:
- Free-run, clk period 10, rst pulse at start, upstream counts 0..15..0..15..3 -> wrap_pulse exactly twice, wraps=2, fault=0, restart_pulse never asserted.
- Upstream rst at count=9 (count 9->0, held 0 for 1 cycle, then 1) -> restart_pulse one cycle, wraps unchanged.
  - Rerun with RESTART_CLR_EN defined -> wraps=0 after restart.
- Force count 5->7 -> fault=1 one cycle later, fault_prev=5, fault_curr=7.
  - Subsequent 15->0 produces no wrap_pulse and wraps stays frozen.
- WRAP_W=2, drive 4 full wraps -> wraps sequence 1,2,3,0; wraps_ovf=1 from the 4th wrap onward.
- Assert rst while in FAULT -> next edge: fault=0, wraps=0, state IDLE.
  - Normal counting then resumes wrap detection after one IDLE sample.
- Hold count constant at 6 for 5 cycles, then 7 -> no pulses, no fault.
